// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding, write-data codes and instruction fields for core_sequencer
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_WAIT_IN = 3'd4,
        S_WRITE   = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_IMM = 2'd1;
    localparam logic [1:0] WD_EXT = 2'd2;

    // Control nibble IR[31:28] = {B, C, W, S}; branch offset IR[12:5]
    localparam int CTL_MSB = 31;
    localparam int CTL_LSB = 28;
    localparam int OFF_MSB = 12;
    localparam int OFF_LSB = 5;
    localparam int CTL_B   = 3;
    localparam int CTL_C   = 2;
    localparam int CTL_W   = 1;
    localparam int CTL_S   = 0;

    typedef struct packed {
        logic       b;
        logic       c;
        logic       halt;
        logic       we;
        logic       wait_in;
        logic [1:0] wd_sel;
    } decode_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decode of the latched instruction's control bits
module instr_decode
    import core_pkg::*;
(
    input  logic [3:0] ctl,
    input  logic [7:0] offset,
    output decode_t    dec
);

    logic w;
    logic s;

    assign w = ctl[CTL_W];
    assign s = ctl[CTL_S];

    always_comb begin
        dec         = '0;
        dec.b       = ctl[CTL_B];
        dec.c       = ctl[CTL_C];
        dec.halt    = ctl[CTL_B] && (offset == 8'd0);
        dec.we      = w | s;
        dec.wait_in = !w && s;
        case ({w, s})
            2'b11:   dec.wd_sel = WD_ALU;
            2'b10:   dec.wd_sel = WD_IMM;
            2'b01:   dec.wd_sel = WD_EXT;
            default: dec.wd_sel = WD_ALU;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute sequencer with run and single-step modes
module core_sequencer
    import core_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [31:0]      INSTR,
    input  logic             ALU_FLAG,
    input  logic             IN_VALID,
    output logic [PC_W-1:0]  PC,
    output logic [31:0]      IR,
    output logic             RF_WE,
    output logic [1:0]       WD_SEL,
    output logic             IN_READY,
    output logic             HALTED,
    output logic [CNT_W-1:0] RETIRED
);

    state_t          state;
    state_t          next_state;
    decode_t         dec;
    logic            run_mode;
    logic            taken;
    logic [PC_W-1:0] off_pc;

    instr_decode u_decode (
        .ctl    (IR[CTL_MSB:CTL_LSB]),
        .offset (IR[OFF_MSB:OFF_LSB]),
        .dec    (dec)
    );

    // Flag is sampled in WRITE, so the branch decision is made there too
    assign taken  = dec.b | (dec.c & ALU_FLAG);
    assign off_pc = PC_W'(IR[OFF_MSB:OFF_LSB]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC       <= '0;
            IR       <= '0;
            RETIRED  <= '0;
            run_mode <= 1'b0;
        end else begin
            if (state == S_IDLE && (RUN || STEP)) begin
                run_mode <= RUN;
            end
            if (state == S_DECODE) begin
                IR <= INSTR;
            end
            if (state == S_WRITE) begin
                if (!dec.halt) begin
                    PC <= taken ? PC + off_pc : PC + PC_W'(1);
                end
                if (RETIRED != '1) begin
                    RETIRED <= RETIRED + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (RUN || STEP) next_state = S_FETCH;
            S_FETCH:   next_state = S_DECODE;
            S_DECODE:  next_state = S_EXEC;
            S_EXEC:    next_state = dec.wait_in ? S_WAIT_IN : S_WRITE;
            S_WAIT_IN: if (IN_VALID) next_state = S_WRITE;
            S_WRITE: begin
                if (dec.halt)             next_state = S_HALT;
                else if (run_mode && RUN) next_state = S_FETCH;
                else                      next_state = S_IDLE;
            end
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        RF_WE    = 1'b0;
        WD_SEL   = WD_ALU;
        IN_READY = 1'b0;
        HALTED   = 1'b0;
        case (state)
            S_WRITE: begin
                RF_WE  = dec.we;
                WD_SEL = dec.wd_sel;
            end
            S_WAIT_IN: IN_READY = 1'b1;
            S_HALT:    HALTED   = 1'b1;
            default: ;
        endcase
    end

endmodule
